// File: rtl/alu_req_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; operands held L cycles (1, MUL_LAT or DIV_LAT).
// Result valid L+1 cycles after accept; held indefinitely under backpressure, no accepts until taken.
module alu_req_arbiter #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_sel,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_dz,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] MUL_L = 4'(MUL_LAT);
  localparam logic [3:0] DIV_L = 4'(DIV_LAT);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        owner;
  logic        last_grant;
  logic        grant0, grant1;
  logic        accept0, accept1, accept;
  logic [31:0] acc_a, acc_b;
  logic [3:0]  acc_sel;

  function automatic logic [3:0] hold_lat(input logic [3:0] sel);
    case (sel)
      4'b0010, 4'b0110, 4'b1110: hold_lat = MUL_L;
      4'b0011, 4'b0111, 4'b1111: hold_lat = DIV_L;
      default:                   hold_lat = 4'd1;
    endcase
  endfunction

  // On a tie the requester that lost last time wins; last_grant resets to 1 so req0 wins first.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  assign accept  = accept0 || accept1;

  assign acc_a   = accept1 ? req1_a   : req0_a;
  assign acc_b   = accept1 ? req1_b   : req0_b;
  assign acc_sel = accept1 ? req1_sel : req0_sel;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_sel    <= 4'd0;
      rsp_data   <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_dz     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a      <= acc_a;
        alu_b      <= acc_b;
        alu_sel    <= acc_sel;
        owner      <= accept1;
        last_grant <= accept1;
        cnt        <= hold_lat(acc_sel);
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
        // Operands have now been stable for the full hold time, so the ALU output is settled.
        if (cnt == 4'd1) begin
          rsp_data <= alu_out;
          rsp_zero <= alu_zero;
          rsp_dz   <= ((alu_sel == 4'b0011) || (alu_sel == 4'b0111)) && (alu_b == 32'd0);
        end
      end
    end
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares one 32-bit combinational ALU between two requesters. Round-robin arbitration, valid/ready handshake on request and response channels. Operands are registered and held stable for a per-opcode hold time that covers the multiply and divide paths. Each result is returned only to the requester that issued it. Sits between the two issue ports and the ALU instance. Drives `alu_a`, `alu_b` and `alu_sel`, and samples `alu_out` and `alu_zero`.

## Interface
- `MUL_LAT`, default 2: hold cycles for opcodes `0010`, `0110`, `1110`. Legal range 1..15.
- `DIV_LAT`, default 4: hold cycles for opcodes `0011`, `0111`, `1111`. Legal range 1..15.
- `clk` in 1: the single clock. All state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req0_a` in 32: requester 0 operand A.
- `req0_b` in 32: requester 0 operand B.
- `req0_sel` in 4: requester 0 opcode, ALU encoding.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same as the requester 0 ports, for requester 1.
- `rsp0_valid` out 1: result available for requester 0.
- `rsp0_ready` in 1: requester 0 takes the result.
- `rsp1_valid` out 1: result available for requester 1.
- `rsp1_ready` in 1: requester 1 takes the result.
- `rsp_data` out 32: result, shared by both response channels.
- `rsp_zero` out 1: registered ALU zero flag for the result.
- `rsp_dz` out 1: divide by zero. Set when the opcode is `0011` or `0111` and B = 0.
- `alu_a` out 32: registered operand A to the ALU.
- `alu_b` out 32: registered operand B to the ALU.
- `alu_sel` out 4: registered opcode to the ALU.
- `alu_out` in 32: ALU result.
- `alu_zero` in 1: ALU zero flag.

## Operation
- FSM states are IDLE, BUSY and RESP. Reset state is IDLE.
- Arbitration in IDLE:
  - If only one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester not granted last time wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- `reqN_ready` is combinational: `(state==IDLE) && grantN`. It is never high for both requesters. It is 0 while `rst_n` is low.
- Accept happens when `reqN_valid && reqN_ready`. On the accept edge:
  - A, B and sel are latched into `alu_a`, `alu_b`, `alu_sel`.
  - The owner bit and `last_grant` are set to N.
  - The hold counter is loaded with L. L = 1 for all other opcodes, `MUL_LAT` for the multiply opcodes, `DIV_LAT` for the divide opcodes.
  - The FSM moves to BUSY.
- BUSY:
  - The counter decrements each cycle.
  - On the edge where the counter is 1: capture `alu_out` into `rsp_data` and `alu_zero` into `rsp_zero`. Compute `rsp_dz` from the latched sel and B. Move to RESP.
- RESP:
  - `rsp<owner>_valid` is 1 and the other `rsp_valid` is 0.
  - On `rsp<owner>_ready`, the next state is IDLE.
  - `rsp_ready` from the non-owner is ignored.
- `alu_*` registers keep their last value outside BUSY. They change only on accept.
- Requests from either port are not accepted while the FSM is in BUSY or RESP. Requesters must hold valid and payload until accepted.
- Reset values:
  - All `*_ready` and `*_valid` outputs are 0.
  - `rsp_data`, `rsp_zero`, `rsp_dz`, `alu_a`, `alu_b` and `alu_sel` are 0.
  - The counter is 0 and the owner is 0.
- Reset mid-operation: state is cleared immediately and the in-flight operation is dropped. No response is issued for it.

## Timing
- Accept at edge T gives BUSY from cycle T+1 to T+L. `rsp_valid` is high starting at cycle T+L+1.
- If `rsp_ready` is already high, the FSM returns to IDLE at T+L+2. The next accept can occur at that edge.
- Minimum issue interval is L+2 cycles. An ALU op takes 3 cycles and a divide with `DIV_LAT`=4 takes 6.
- The response is held stable indefinitely under backpressure. Arbitration stalls for the whole time.
- The ALU path is combinational, so `alu_out` is sampled L cycles after the operands were registered.

## Test plan
- **Single add.** Req0 A=5, B=7, sel `0000`, accepted at T. `alu_out`=12 is driven by the ALU model. Required: `rsp0_valid`=1 at T+2 with `rsp_data`=12, `rsp_zero`=0 and `rsp1_valid`=0.
- **Tie after reset.** Both requests are valid in the first cycle. Required:
  - Req0 is granted first and req1 second.
  - A second tie is then granted to req0 again.
  - The two `reqN_ready` signals are never both high.
- **Divide latency.** Req1 A=100, B=7, sel `0011`, with `DIV_LAT`=4. Required: `rsp1_valid` rises exactly 5 cycles after accept with `rsp_data`=14. The `alu_*` outputs are stable throughout BUSY.
- **Divide by zero.** A=9, B=0, sel `0111`. Required: `rsp_dz`=1, `rsp_data`=0, `rsp_zero`=1.
- **Backpressure.** Hold `rsp0_ready`=0 for 10 cycles while req1 is valid. Required:
  - `rsp_data` stays stable during the stall.
  - `req1_ready` stays 0.
  - Req1 is accepted on the cycle after `rsp0_ready` goes high.
- **Reset mid-BUSY.** Assert `rst_n` low while a divide is in flight. Required:
  - All outputs go to 0 asynchronously.
  - After release, no response is issued for the dropped divide.
  - A new add completes normally.
